prescaled_timer: RTL and testbench
==================================

Name: prescaled_timer

Overview:
- Parametrised successor to the free-running counter.
- Adds a prescaler, a programmable period with wrap and a match pulse, periodic or one-shot mode, start/stop control, and an optional capture register.
- Serves as the general timebase/interval timer for generated designs, e.g. tick generation, timeouts and elapsed-time measurement.

Parameters:
DATA_WIDTH, 32, width of counter, period and captured value
PRESCALE_WIDTH, 16, width of the prescale divider input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
reset_counter  in  1  synchronous clear of counter and prescaler; state unchanged
enable  in  1  gate; 0 freezes prescaler and counter while RUN
mode  in  1  0 = periodic, 1 = one-shot
start  in  1  pulse; IDLE/DONE -> RUN
stop  in  1  pulse; RUN -> IDLE, counter held
prescale  in  PRESCALE_WIDTH  tick every prescale+1 enabled clocks
period  in  DATA_WIDTH  terminal count (unsigned)
capture  in  1  pulse; latch current counter
data  out  signed DATA_WIDTH  counter value
captured  out  DATA_WIDTH  last captured counter value
match  out  1  one-cycle pulse on terminal count
running  out  1  high in RUN

Behaviour:
- Reset (async): state IDLE, counter 0, prescaler 0, match 0, captured 0, running 0.
- States:
  - IDLE: counter and prescaler hold.
  - RUN: counting.
  - DONE: one-shot finished; counter 0, prescaler 0.
- Transitions:
  - IDLE -> RUN on start.
  - DONE -> RUN on start; counter restarts from 0.
  - RUN -> IDLE on stop; counter keeps its value, and start resumes from it.
  - RUN -> DONE on a terminal tick when mode = 1.
  - Periodic mode stays in RUN.
  - start and stop in the same cycle: stop wins. In IDLE/DONE, both together = no change.
- Prescaler (RUN and enable = 1 only):
  - Counts 0..prescale.
  - tick is asserted in the cycle prescaler == prescale, which also reloads the prescaler to 0.
  - prescale = 0: tick every enabled cycle.
  - prescale is compared live.
  - If prescale is lowered below the current prescaler value, the prescaler wraps naturally at 2^PRESCALE_WIDTH-1 without a tick, then resumes.
- Counter on tick:
  - If counter >= period (unsigned): counter <= 0 and match <= 1 on the next cycle, i.e. registered with 1-cycle latency from the terminal tick.
  - Otherwise counter <= counter + 1.
  - Period P therefore gives P+1 ticks per wrap. period = 0 gives a match on every tick.
  - The >= comparison recovers cleanly when period is lowered below the counter.
- match is high for exactly one cycle per terminal tick, otherwise 0.
- running = (state == RUN), registered.
- reset_counter: counter <= 0 and prescaler <= 0.
  - Overrides the tick in the same cycle.
  - No match is generated.
  - State is unaffected.
  - If asserted in DONE, the state stays DONE.
- enable = 0 in RUN: prescaler and counter freeze; match is not generated.
- data = counter, reinterpreted as signed, with zero combinational logic.
- Arithmetic wraps modulo 2^DATA_WIDTH; no saturation.
- capture: captured <= counter value present in that cycle (pre-update).
  - Valid in any state.
  - Captured simultaneously with reset_counter: the pre-clear value is latched.

Optional Feature:
- Macro PRESCALED_TIMER_CAPTURE_EN.
- Defined: capture register implemented as described.
- Undefined:
  - No capture register is synthesised.
  - The capture input is ignored.
  - captured is tied to 0.
  - Port list is unchanged in both configurations.

Test Plan:
- reset high mid-count (counter = 7) -> all outputs 0 and state IDLE immediately (asynchronously), no clock edge needed.
- prescale = 0, period = 3, mode = 0, start pulse -> counter 0,1,2,3,0,...; match one-cycle pulse the cycle after each 3->0 wrap; running = 1.
- prescale = 2, period = 1, mode = 1, start -> counter increments every 3 clocks: 0->1->0, then a single match, running drops, DONE holds 0; second start restarts the sequence.
- Counter at 5, stop and start in the same cycle -> IDLE, counter holds 5; later start -> resumes 6,7,...
- Counter at 10, period changed to 4 -> next tick wraps to 0 with a match; simultaneous reset_counter and tick -> counter 0, no match.
- Macro defined: capture at counter = 9 together with reset_counter -> captured = 9, counter 0. Macro undefined: captured stays 0.

Source files
------------

// File: rtl/prescaled_timer_if.sv
// Control/status bundle for prescaled_timer: the master drives the controls, the timer (slave) drives status.
interface prescaled_timer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
);
  logic                        reset_counter;
  logic                        enable;
  logic                        mode;
  logic                        start;
  logic                        stop;
  logic [PRESCALE_WIDTH-1:0]   prescale;
  logic [DATA_WIDTH-1:0]       period;
  logic                        capture;
  logic signed [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0]       captured;
  logic                        match;
  logic                        running;

  modport master (
    output reset_counter, enable, mode, start, stop, prescale, period, capture,
    input  data, captured, match, running
  );

  modport slave (
    input  reset_counter, enable, mode, start, stop, prescale, period, capture,
    output data, captured, match, running
  );
endinterface

// File: rtl/prescaled_timer.sv
// Prescaled interval timer: periodic or one-shot, with a programmable period and a one-cycle match pulse.
// Define PRESCALED_TIMER_CAPTURE_EN to build the capture register; otherwise captured is tied to 0.
module prescaled_timer #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  prescaled_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [DATA_WIDTH-1:0]     counter;
  logic                      match_q;
  logic                      running_q;

  logic counting;
  logic tick;
  logic terminal;
  logic launch;

  // stop and reset_counter both suppress counting in the cycle they are seen
  assign counting = (state == RUN) && bus.enable && !bus.stop && !bus.reset_counter;
  assign tick     = counting && (prescaler == bus.prescale);
  assign terminal = tick && (counter >= bus.period);
  assign launch   = (state != RUN) && bus.start && !bus.stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      counter   <= '0;
      match_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      match_q <= terminal;

      case (state)
        IDLE: begin
          if (launch) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state     <= IDLE;
            running_q <= 1'b0;
          end else if (terminal && bus.mode) begin
            state     <= DONE;
            running_q <= 1'b0;
          end
        end
        DONE: begin
          if (launch) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase

      // A prescaler lowered below its current value simply wraps through all ones before ticking again
      if (bus.reset_counter || ((state == DONE) && launch)) begin
        counter   <= '0;
        prescaler <= '0;
      end else if (tick) begin
        prescaler <= '0;
        counter   <= terminal ? '0 : counter + 1'b1;
      end else if (counting) begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  assign bus.data    = counter;
  assign bus.match   = match_q;
  assign bus.running = running_q;

`ifdef PRESCALED_TIMER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] captured_q;

  // Latches the pre-update counter, so a capture alongside reset_counter keeps the old count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured_q <= '0;
    end else if (bus.capture) begin
      captured_q <= counter;
    end
  end

  assign bus.captured = captured_q;
`else
  logic unused_capture;
  assign unused_capture = bus.capture;
  assign bus.captured   = '0;
`endif

endmodule

// File: tb/tb_prescaled_timer.sv
// Directed self-checking bench for prescaled_timer; inputs change and outputs are sampled on the falling edge.
module tb_prescaled_timer;

  localparam int DW = 32;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset;
  int   compare_count  = 0;
  int   mismatch_count = 0;

  prescaled_timer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

  prescaled_timer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int exp_data, input bit exp_match, input bit exp_running);
    checkOutput({tag, ".data"},    bus.data,    DW'(exp_data));
    checkOutput({tag, ".match"},   DW'(bus.match),   DW'(exp_match));
    checkOutput({tag, ".running"}, DW'(bus.running), DW'(exp_running));
  endtask

  // Holds the pulse inputs for one clock edge and returns on the following falling edge
  task automatic applyStimulus(input bit st, input bit sp, input bit rc, input bit cap);
    bus.start         = st;
    bus.stop          = sp;
    bus.reset_counter = rc;
    bus.capture       = cap;
    @(negedge clk);
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.reset_counter = 1'b0;
    bus.capture       = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.reset_counter = 1'b0;
    bus.enable        = 1'b1;
    bus.mode          = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.capture       = 1'b0;
    bus.prescale      = '0;
    bus.period        = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkState("reset", 0, 1'b0, 1'b0);
    checkOutput("reset.captured", bus.captured, '0);

    // Periodic, prescale 0, period 3: 0,1,2,3,0,... with match alongside each 0 after a wrap
    bus.period = 3;
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(j == 1, 1'b0, 1'b0, 1'b0);
      checkState($sformatf("periodic[%0d]", j), (j - 1) % 4, (j > 1) && ((j - 1) % 4 == 0), 1'b1);
    end

    // Count up to 7, then assert reset away from any clock edge
    bus.period = 20;
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("premidreset", 7, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 checkState("asyncreset", 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // One-shot, prescale 2, period 1: ticks every 3 clocks, 0->1->0, single match, then DONE
    bus.mode     = 1'b1;
    bus.prescale = 2;
    bus.period   = 1;
    for (int run = 0; run < 2; run++) begin
      for (int j = 1; j <= 9; j++) begin
        applyStimulus(j == 1, 1'b0, 1'b0, 1'b0);
        checkState($sformatf("oneshot%0d[%0d]", run, j), (j >= 4 && j <= 6) ? 1 : 0, j == 7, j < 7);
      end
    end

    // stop and start together: stop wins, counter holds and later resumes
    pulseReset();
    bus.mode     = 1'b0;
    bus.prescale = 0;
    bus.period   = 20;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("resume.start", 0, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("resume.at5", 5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkState("resume.stopwins", 5, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("resume.idlehold", 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkState("resume.idleboth", 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("resume.restart", 5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("resume.six", 6, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("resume.seven", 7, 1'b0, 1'b1);

    // Period lowered below the counter wraps on the next tick
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("lower.at10", 10, 1'b0, 1'b1);
    bus.period = 4;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("lower.wrap", 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("lower.after", 1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("lower.atperiod", 4, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkState("clear.overtick", 0, 1'b0, 1'b1);

    // Capture together with reset_counter keeps the pre-clear value
    bus.period = 20;
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("capture.at9", 9, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkState("capture.clear", 0, 1'b0, 1'b1);
`ifdef PRESCALED_TIMER_CAPTURE_EN
    checkOutput("capture.value", bus.captured, 9);
`else
    checkOutput("capture.value", bus.captured, 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("capture.next", 1, 1'b0, 1'b1);

    // enable low freezes the count while staying in RUN
    bus.enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkState($sformatf("freeze[%0d]", j), 1, 1'b0, 1'b1);
    end
    bus.enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("unfreeze", 2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
